// File: rtl/core_test_monitor.sv
`default_nettype none
// ============================================================================
// Module   : core_test_monitor
// Purpose  : Watches a core's register-file writeback port during a self-test
//            program. Keeps shadow copies of selected architectural registers.
//            Ends the test when the trigger register gets a nonzero write.
//            After a settle window it reports pass/fail and the step number.
//            It reports a timeout if the trigger never comes.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            start_i          - one-cycle pulse, arms/re-arms the monitor
//            wb_we_i/rd_i/data_i - core register writeback port
//            done_o           - test finished (held until rst or start)
//            pass_o/fail_o    - result of the check (mutually exclusive)
//            timeout_o        - cycle limit hit before the trigger
//            step_o           - step-register shadow latched at check time
//            cycles_o         - saturating count of RUN+SETTLE cycles
//            watch_bus_o      - live shadows, slot i at [XLEN*i +: XLEN]
// Revision : 1.0 - initial release
// ============================================================================
module core_test_monitor #(
  parameter int                  XLEN      = 32,
  parameter int                  NWATCH    = 4,
  parameter logic [NWATCH*5-1:0] WATCH_IDX = {5'd13, 5'd12, 5'd7, 5'd5},
  parameter int                  TRIG_REG  = 26,
  parameter int                  PASS_REG  = 27,
  parameter int                  PASS_VAL  = 1,
  parameter int                  STEP_REG  = 3,
  parameter int                  SETTLE    = 10,
  parameter int                  TIMEOUT   = 100000,
  parameter int                  CW        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     wb_we_i,
  input  logic [4:0]               wb_rd_i,
  input  logic [XLEN-1:0]          wb_data_i,
  output logic                     done_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     timeout_o,
  output logic [XLEN-1:0]          step_o,
  output logic [CW-1:0]            cycles_o,
  output logic [NWATCH*XLEN-1:0]   watch_bus_o
);

  localparam logic [4:0]      c_trig_idx    = 5'(TRIG_REG);
  localparam logic [4:0]      c_pass_idx    = 5'(PASS_REG);
  localparam logic [4:0]      c_step_idx    = 5'(STEP_REG);
  localparam logic [XLEN-1:0] c_pass_val    = XLEN'(PASS_VAL);
  localparam logic [7:0]      c_settle_init = 8'(SETTLE - 1);
  localparam logic [CW-1:0]   c_to_lim      = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        settle_q, settle_d;
  logic [CW-1:0]     cycles_q, cycles_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [XLEN-1:0]   step_q, step_d;
  logic [XLEN-1:0]   pass_sh_q, pass_sh_d;
  logic [XLEN-1:0]   step_sh_q, step_sh_d;
  logic [XLEN-1:0]   watch_q [NWATCH];
  logic [XLEN-1:0]   watch_d [NWATCH];

  logic              w_wr_ok;
  logic              w_trig_hit;
  logic              w_shadow_en;
  logic              w_pass_ok;
  logic [CW-1:0]     w_cyc_inc;

  // x0 is hardwired to zero in the core, so its writes never reach a shadow.
  assign w_wr_ok    = wb_we_i && (wb_rd_i != 5'd0);
  // The trigger is decided from the write itself; no copy of the trigger
  // register is needed because nothing reads it afterwards.
  assign w_trig_hit = w_wr_ok && (wb_rd_i == c_trig_idx) && (wb_data_i != '0);
  assign w_cyc_inc  = (&cycles_q) ? cycles_q : cycles_q + CW'(1);
  assign w_pass_ok  = (pass_sh_q == c_pass_val);
  // A start pulse restarts the test, so a write in that cycle is dropped.
  assign w_shadow_en = ((state_q == S_RUN) || (state_q == S_SETTLE)) && !start_i;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    cycles_d  = cycles_q;
    done_d    = done_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    step_d    = step_q;
    pass_sh_d = pass_sh_q;
    step_sh_d = step_sh_q;
    watch_d   = watch_q;

    if (start_i) begin
      state_d   = S_RUN;
      settle_d  = '0;
      cycles_d  = '0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      fail_d    = 1'b0;
      timeout_d = 1'b0;
      step_d    = '0;
      pass_sh_d = '0;
      step_sh_d = '0;
      for (int i = 0; i < NWATCH; i++) watch_d[i] = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          cycles_d = w_cyc_inc;
          // Trigger takes priority over a timeout landing in the same cycle.
          if (w_trig_hit) begin
            state_d  = S_SETTLE;
            settle_d = c_settle_init;
          end else if (w_cyc_inc >= c_to_lim) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
        S_SETTLE: begin
          cycles_d = w_cyc_inc;
          if (settle_q == 8'd0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = w_pass_ok;
            fail_d  = !w_pass_ok;
            step_d  = step_sh_q;
          end else begin
            settle_d = settle_q - 8'd1;
          end
        end
        S_DONE: ;
      endcase
    end

    if (w_shadow_en && w_wr_ok) begin
      if (wb_rd_i == c_pass_idx) pass_sh_d = wb_data_i;
      if (wb_rd_i == c_step_idx) step_sh_d = wb_data_i;
      for (int i = 0; i < NWATCH; i++) begin
        if (wb_rd_i == WATCH_IDX[5*i +: 5]) watch_d[i] = wb_data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      cycles_q  <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      step_q    <= '0;
      pass_sh_q <= '0;
      step_sh_q <= '0;
      for (int i = 0; i < NWATCH; i++) watch_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      step_q    <= step_d;
      pass_sh_q <= pass_sh_d;
      step_sh_q <= step_sh_d;
      for (int i = 0; i < NWATCH; i++) watch_q[i] <= watch_d[i];
    end
  end

  assign done_o    = done_q;
  assign pass_o    = pass_q;
  assign fail_o    = fail_q;
  assign timeout_o = timeout_q;
  assign step_o    = step_q;
  assign cycles_o  = cycles_q;

  generate
    for (genvar g = 0; g < NWATCH; g++) begin : g_watch_bus
      assign watch_bus_o[XLEN*g +: XLEN] = watch_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_core_test_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_core_test_monitor
// Purpose  : Directed, table-driven bench for core_test_monitor (TIMEOUT=50,
//            other parameters default) plus hand-written multi-cycle cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_test_monitor;

  localparam int XLEN   = 32;
  localparam int NWATCH = 4;
  localparam int CW     = 32;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_i;
  logic                   wb_we_i;
  logic [4:0]             wb_rd_i;
  logic [XLEN-1:0]        wb_data_i;
  logic                   done_o;
  logic                   pass_o;
  logic                   fail_o;
  logic                   timeout_o;
  logic [XLEN-1:0]        step_o;
  logic [CW-1:0]          cycles_o;
  logic [NWATCH*XLEN-1:0] watch_bus_o;

  always #5 clk = ~clk;

  core_test_monitor #(.TIMEOUT(50)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .wb_we_i     (wb_we_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .fail_o      (fail_o),
    .timeout_o   (timeout_o),
    .step_o      (step_o),
    .cycles_o    (cycles_o),
    .watch_bus_o (watch_bus_o)
  );

  // flags = {done, pass, fail, timeout}
  typedef struct {
    logic         st;
    logic         we;
    logic [4:0]   rd;
    logic [31:0]  data;
    logic [3:0]   flags;
    logic [31:0]  step;
    logic [31:0]  cyc;
    logic [127:0] watch;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic st, input logic we, input logic [4:0] rd,
                              input logic [31:0] data, input logic [3:0] flags,
                              input logic [31:0] step, input logic [31:0] cyc,
                              input logic [127:0] watch);
    vec_t v;
    v.st = st; v.we = we; v.rd = rd; v.data = data;
    v.flags = flags; v.step = step; v.cyc = cyc; v.watch = watch;
    tbl.push_back(v);
  endfunction

  // start; x27=1, x3=5, x26=1; done+pass exactly 10 cycles after the trigger
  function automatic void add_pass_case();
    add(1, 0, 0, 0, 4'b0000, 0, 0, '0);
    add(0, 1, 27, 1, 4'b0000, 0, 1, '0);
    add(0, 1, 3, 5, 4'b0000, 0, 2, '0);
    add(0, 1, 26, 1, 4'b0000, 0, 3, '0);
    for (int n = 4; n <= 12; n++) add(0, 0, 0, 0, 4'b0000, 0, n, '0);
    add(0, 0, 0, 0, 4'b1100, 5, 13, '0);
    add(0, 1, 27, 0, 4'b1100, 5, 13, '0);
  endfunction

  task automatic chk(input string name, input logic [127:0] act_v, input logic [127:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act_v, exp_v);
    end
  endtask

  task automatic check_row(input string name, input logic [3:0] flags, input logic [31:0] step,
                           input logic [31:0] cyc, input logic [127:0] watch);
    chk({name, " flags"}, {124'b0, done_o, pass_o, fail_o, timeout_o}, {124'b0, flags});
    chk({name, " step"}, {96'b0, step_o}, {96'b0, step});
    chk({name, " cycles"}, {96'b0, cycles_o}, {96'b0, cyc});
    chk({name, " watch"}, watch_bus_o, watch);
  endtask

  task automatic cyc(input logic st, input logic we, input logic [4:0] rd, input logic [31:0] data);
    start_i = st; wb_we_i = we; wb_rd_i = rd; wb_data_i = data;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start_i = 1'b0; wb_we_i = 1'b0; wb_rd_i = '0; wb_data_i = '0;
    @(negedge clk);
    cyc(0, 0, 0, 0);
    check_row("reset", 4'b0000, 0, 0, '0);
    rst = 1'b0;

    // ---------------- vector table ----------------
    add_pass_case();
    // start from DONE clears everything; x27=0, x26=7 -> fail
    add(1, 0, 0, 0, 4'b0000, 0, 0, '0);
    add(0, 1, 27, 0, 4'b0000, 0, 1, '0);
    add(0, 1, 26, 7, 4'b0000, 0, 2, '0);
    for (int n = 3; n <= 11; n++) add(0, 0, 0, 0, 4'b0000, 0, n, '0);
    add(0, 0, 0, 0, 4'b1010, 0, 12, '0);
    // shadowing of watched slots; x0 write has no effect
    add(1, 0, 0, 0, 4'b0000, 0, 0, '0);
    add(0, 1, 5, 32'hA5, 4'b0000, 0, 1, {32'h0, 32'h0, 32'h0, 32'hA5});
    add(0, 1, 12, 32'hA5, 4'b0000, 0, 2, {32'h0, 32'hA5, 32'h0, 32'hA5});
    add(0, 1, 13, 32'hA0, 4'b0000, 0, 3, {32'hA0, 32'hA5, 32'h0, 32'hA5});
    add(0, 1, 0, 32'hFF, 4'b0000, 0, 4, {32'hA0, 32'hA5, 32'h0, 32'hA5});
    // restart mid-RUN with a write in the same cycle: write discarded
    add(1, 1, 5, 32'h11, 4'b0000, 0, 0, '0);
    // timeout run: done at cycles=49
    for (int n = 1; n <= 48; n++) add(0, 0, 0, 0, 4'b0000, 0, n, '0);
    add(0, 0, 0, 0, 4'b1001, 0, 49, '0);
    add(0, 1, 5, 32'h77, 4'b1001, 0, 49, '0);
    add(0, 1, 26, 1, 4'b1001, 0, 49, '0);
    // trigger in the same cycle the timeout limit is reached: trigger wins
    add(1, 0, 0, 0, 4'b0000, 0, 0, '0);
    for (int n = 1; n <= 48; n++) add(0, 0, 0, 0, 4'b0000, 0, n, '0);
    add(0, 1, 26, 1, 4'b0000, 0, 49, '0);
    for (int n = 50; n <= 58; n++) add(0, 0, 0, 0, 4'b0000, 0, n, '0);
    add(0, 0, 0, 0, 4'b1010, 0, 59, '0);
    // rerun the pass case from DONE
    add_pass_case();

    foreach (tbl[i]) begin
      cyc(tbl[i].st, tbl[i].we, tbl[i].rd, tbl[i].data);
      check_row($sformatf("vec%0d", i), tbl[i].flags, tbl[i].step, tbl[i].cyc, tbl[i].watch);
    end

    // ---------------- late PASS write during SETTLE ----------------
    cyc(1, 0, 0, 0);
    cyc(0, 1, 26, 1);
    cyc(0, 1, 27, 1);
    for (int n = 0; n < 8; n++) cyc(0, 0, 0, 0);
    check_row("late_pre", 4'b0000, 0, 10, '0);
    cyc(0, 0, 0, 0);
    check_row("late_done", 4'b1100, 0, 11, '0);

    // ---------------- reset mid-SETTLE, with start and write ----------------
    cyc(1, 0, 0, 0);
    cyc(0, 1, 5, 32'h5A);
    cyc(0, 1, 26, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check_row("settle_pre", 4'b0000, 0, 4, {32'h0, 32'h0, 32'h0, 32'h5A});
    rst = 1'b1;
    cyc(1, 1, 5, 32'h33);
    rst = 1'b0;
    check_row("rst_mid", 4'b0000, 0, 0, '0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 5, 32'h44);
    cyc(0, 0, 0, 0);
    check_row("idle_after_rst", 4'b0000, 0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_test_monitor.md
CORE_TEST_MONITOR -- requirements
Module: core_test_monitor

Interface
REQ-001 Parameter XLEN, default 32, width of the register-writeback data.
REQ-002 Parameter NWATCH, default 4, number of shadowed architectural registers (1..16).
REQ-003 Parameter WATCH_IDX, default {5'd13,5'd12,5'd7,5'd5}, NWATCH*5-bit packed list of watched register indices; slot i is bits [5i+4:5i].
REQ-004 Parameter TRIG_REG, default 26, register whose nonzero write ends the test.
REQ-005 Parameter PASS_REG, default 27, register holding the result flag.
REQ-006 Parameter PASS_VAL, default 1, value of PASS_REG meaning pass.
REQ-007 Parameter STEP_REG, default 3, register holding the test step number.
REQ-008 Parameter SETTLE, default 10, cycles waited after the trigger before checking (1..255).
REQ-009 Parameter TIMEOUT, default 100000, cycle limit for RUN.
REQ-010 Parameter CW, default 32, cycle-counter width.
REQ-011 clk  in  1  single clock; all logic on its rising edge.
REQ-012 rst  in  1  synchronous, active-high reset.
REQ-013 start  in  1  one-cycle pulse that arms the monitor.
REQ-014 wb_we  in  1  core register-file write enable.
REQ-015 wb_rd  in  5  destination register index of the write.
REQ-016 wb_data  in  XLEN  write data.
REQ-017 done  out  1  test finished (pass, fail or timeout); held until rst or start.
REQ-018 pass  out  1  PASS_REG shadow equalled PASS_VAL at check time.
REQ-019 fail  out  1  check performed and mismatched.
REQ-020 timeout  out  1  TIMEOUT reached before the trigger.
REQ-021 step  out  XLEN  STEP_REG shadow, latched at check time.
REQ-022 cycles  out  CW  cycles spent in RUN and SETTLE.
REQ-023 watch_bus  out  NWATCH*XLEN  live shadow values; slot i at [XLEN*i+XLEN-1:XLEN*i].

Function
REQ-024 States: IDLE, RUN, SETTLE, DONE; encoding is free.
REQ-025 IDLE->RUN on start; this also clears the shadows, cycles, step and all flags.
REQ-026 Shadowing is active in RUN and SETTLE only: when wb_we=1 and wb_rd!=0, every watched slot, and the internal TRIG, PASS and STEP shadows, whose index equals wb_rd takes wb_data the next cycle.
REQ-027 Writes with wb_rd=0 are ignored everywhere, so x0 shadows stay 0.
REQ-028 RUN->SETTLE in the cycle after a write to TRIG_REG with wb_data!=0; the settle counter loads SETTLE-1.
REQ-029 In SETTLE, writes are still shadowed; the counter decrements each cycle; at 0 go to DONE.
REQ-030 Entry to DONE after SETTLE: pass=(PASS shadow==PASS_VAL), fail=~pass, step=STEP shadow, done=1, all in the same cycle.
REQ-031 cycles increments once per cycle in RUN and SETTLE, saturates at all-ones, and freezes in DONE.
REQ-032 RUN->DONE with timeout=1, pass=0, fail=0 when cycles reaches TIMEOUT-1 with no trigger; if the trigger write and this limit fall in the same cycle, the trigger wins.
REQ-033 In DONE, wb_* is ignored and shadows and outputs hold; start re-arms (DONE->RUN with clear).
REQ-034 start while in RUN or SETTLE restarts: go to RUN with everything cleared; a write in the same cycle is discarded.
REQ-035 pass, fail and timeout are mutually exclusive; at most one is 1, and only when done=1.
REQ-036 Outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-037 rst=1 at any clock edge forces IDLE and zeroes done, pass, fail, timeout, step, cycles, watch_bus and all internal shadows and counters, including mid-RUN or mid-SETTLE.
REQ-038 rst has priority over start and wb_we in the same cycle.

Verification
REQ-039 Defaults: start; write x27=1, x3=5, then x26=1 -> done=1 and pass=1 exactly SETTLE cycles after the x26 write; step=5.
REQ-040 Start; write x27=0, x26=7 -> fail=1, pass=0, timeout=0, done=1.
REQ-041 TIMEOUT=50, start, no trigger -> done=1 and timeout=1 at cycles=49; later wb writes change nothing.
REQ-042 Start; write x5=0xA5, x12=0xA5, x13=0xA0, x0=0xFF -> watch_bus slots 0..3 = A5,0,A5,A0; no x0 effect.
REQ-043 Trigger, then write x27=1 during SETTLE -> pass=1 (late write counted); rst mid-SETTLE -> all outputs 0, state IDLE.
REQ-044 Second start pulse during DONE -> flags clear and cycles=0 the next cycle; rerunning the pass case passes again.
